// File: rtl/noc_output_arbiter.sv
// noc_output_arbiter: packet-level round-robin arbiter sharing one registered router output port.
// Define NOC_ARB_WATCHDOG_EN to add the locked-stall counter and sticky stall_err output.
module noc_output_arbiter #(
    parameter int FLIT_WIDTH = 32,
    parameter int INPUTS = 5,
    parameter int STALL_LIMIT = 256,
    localparam int IDXW = (INPUTS > 1) ? $clog2(INPUTS) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [INPUTS-1:0][FLIT_WIDTH-1:0] in_flit,
    input  logic [INPUTS-1:0]                in_last,
    input  logic [INPUTS-1:0]                in_valid,
    output logic [INPUTS-1:0]                in_ready,
    output logic [FLIT_WIDTH-1:0]            out_flit,
    output logic                             out_last,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [IDXW-1:0]                  out_owner
`ifdef NOC_ARB_WATCHDOG_EN
    ,
    output logic                             stall_err
`endif
);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t state, state_next;
    logic [IDXW-1:0] rr_ptr, lock_idx, rr_grant, grant, rr_next, j;
    logic found, has_grant, slot_free, xfer;

    always_comb begin
        rr_grant = rr_ptr;
        found = 1'b0;
        j = '0;
        for (int k = 0; k < INPUTS; k++) begin
            j = IDXW'((int'(rr_ptr) + k) % INPUTS);
            if (!found && in_valid[j]) begin
                found = 1'b1;
                rr_grant = j;
            end
        end
        grant = (state == LOCKED) ? lock_idx : rr_grant;
        has_grant = (state == LOCKED) || found;
        slot_free = !out_valid || out_ready;
        in_ready = (rst && has_grant && slot_free) ? (INPUTS'(1) << grant) : '0;
        xfer = rst && has_grant && slot_free && in_valid[grant];
        rr_next = (grant == IDXW'(INPUTS - 1)) ? '0 : grant + 1'b1;
        state_next = state;
        if (xfer) state_next = in_last[grant] ? IDLE : LOCKED;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            rr_ptr <= '0;
            lock_idx <= '0;
            out_valid <= 1'b0;
            out_flit <= '0;
            out_last <= 1'b0;
            out_owner <= '0;
        end else begin
            state <= state_next;
            if (xfer) begin
                out_flit <= in_flit[grant];
                out_last <= in_last[grant];
                out_valid <= 1'b1;
                out_owner <= grant;
                if (in_last[grant]) rr_ptr <= rr_next;
                else lock_idx <= grant;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef NOC_ARB_WATCHDOG_EN
    // Counts consecutive locked cycles without a transfer; saturates at the limit.
    localparam int CW = $clog2(STALL_LIMIT + 1);
    logic [CW-1:0] stall_cnt, stall_cnt_next;

    always_comb begin
        stall_cnt_next = '0;
        if (state == LOCKED && !xfer)
            stall_cnt_next = (stall_cnt == CW'(STALL_LIMIT)) ? stall_cnt : stall_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
            stall_err <= 1'b0;
        end else begin
            stall_cnt <= stall_cnt_next;
            stall_err <= stall_err || (stall_cnt_next == CW'(STALL_LIMIT));
        end
    end
`endif
endmodule

// File: tb/tb_noc_output_arbiter.sv
// tb_noc_output_arbiter: table-driven directed bench for noc_output_arbiter (INPUTS=5).
// Define NOC_ARB_WATCHDOG_EN to also exercise the stall watchdog with STALL_LIMIT=8.
module tb_noc_output_arbiter;
    localparam int FW = 32;
    localparam int N = 5;
    localparam int SL = 8;
    localparam int IW = 3;

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0][FW-1:0] in_flit;
    logic [N-1:0] in_last, in_valid, in_ready;
    logic [FW-1:0] out_flit;
    logic out_last, out_valid, out_ready;
    logic [IW-1:0] out_owner;
`ifdef NOC_ARB_WATCHDOG_EN
    logic stall_err;
`endif
    int checks = 0;
    int fails = 0;

    always #5 clk = ~clk;

    noc_output_arbiter #(.FLIT_WIDTH(FW), .INPUTS(N), .STALL_LIMIT(SL)) dut (
        .clk(clk),
        .rst(rst),
        .in_flit(in_flit),
        .in_last(in_last),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_flit(out_flit),
        .out_last(out_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_owner(out_owner)
`ifdef NOC_ARB_WATCHDOG_EN
        ,
        .stall_err(stall_err)
`endif
    );

    typedef struct {
        logic [N-1:0] v;
        logic [N-1:0] l;
        logic ordy;
        logic [N-1:0] rdy;
        logic ov;
        logic [IW-1:0] own;
    } vec_t;

    vec_t tbl[17];

    function automatic logic [FW-1:0] fl(input int i, input int k);
        return FW'(i * 256 + k);
    endfunction

    task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l, input logic ordy, input int tag);
        for (int i = 0; i < N; i++) in_flit[i] = fl(i, tag);
        in_valid = v;
        in_last = l;
        out_ready = ordy;
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // v, l, out_ready, expected in_ready, expected out_valid, expected owner
        tbl[0]  = '{5'b01010, 5'b01010, 1'b1, 5'b00010, 1'b1, 3'd1};
        tbl[1]  = '{5'b01010, 5'b01010, 1'b1, 5'b01000, 1'b1, 3'd3};
        tbl[2]  = '{5'b01010, 5'b01010, 1'b1, 5'b00010, 1'b1, 3'd1};
        tbl[3]  = '{5'b01010, 5'b01010, 1'b1, 5'b01000, 1'b1, 3'd3};
        tbl[4]  = '{5'b00001, 5'b00001, 1'b1, 5'b00001, 1'b1, 3'd0};
        tbl[5]  = '{5'b00101, 5'b00000, 1'b1, 5'b00100, 1'b1, 3'd2};
        tbl[6]  = '{5'b00101, 5'b00000, 1'b1, 5'b00100, 1'b1, 3'd2};
        tbl[7]  = '{5'b00101, 5'b00000, 1'b1, 5'b00100, 1'b1, 3'd2};
        tbl[8]  = '{5'b00101, 5'b00100, 1'b1, 5'b00100, 1'b1, 3'd2};
        tbl[9]  = '{5'b00001, 5'b00001, 1'b1, 5'b00001, 1'b1, 3'd0};
        tbl[10] = '{5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 3'd0};
        tbl[11] = '{5'b10000, 5'b10000, 1'b1, 5'b10000, 1'b1, 3'd4};
        tbl[12] = '{5'b01001, 5'b01001, 1'b1, 5'b00001, 1'b1, 3'd0};
        tbl[13] = '{5'b00010, 5'b00000, 1'b1, 5'b00010, 1'b1, 3'd1};
        tbl[14] = '{5'b00100, 5'b00100, 1'b1, 5'b00010, 1'b0, 3'd1};
        tbl[15] = '{5'b00110, 5'b00010, 1'b1, 5'b00010, 1'b1, 3'd1};
        tbl[16] = '{5'b00100, 5'b00100, 1'b1, 5'b00100, 1'b1, 3'd2};

        rst = 1'b0;
        drive('1, '0, 1'b1, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1 chk("reset in_ready", FW'(in_ready), 0);
            edge_wait();
            chk("reset out_valid", FW'(out_valid), 0);
            chk("reset out_owner", FW'(out_owner), 0);
`ifdef NOC_ARB_WATCHDOG_EN
            chk("reset stall_err", FW'(stall_err), 0);
`endif
        end
        @(negedge clk);
        rst = 1'b1;

        for (int k = 0; k < 17; k++) begin
            drive(tbl[k].v, tbl[k].l, tbl[k].ordy, k);
            #1 chk($sformatf("row%0d in_ready", k), FW'(in_ready), FW'(tbl[k].rdy));
            edge_wait();
            chk($sformatf("row%0d out_valid", k), FW'(out_valid), FW'(tbl[k].ov));
            if (tbl[k].ov) begin
                chk($sformatf("row%0d out_owner", k), FW'(out_owner), FW'(tbl[k].own));
                chk($sformatf("row%0d out_flit", k), out_flit, fl(int'(tbl[k].own), k));
                chk($sformatf("row%0d out_last", k), FW'(out_last), FW'(tbl[k].l[tbl[k].own]));
            end
            @(negedge clk);
        end

        // Backpressure mid-packet: output holds, nothing is accepted, then resumes in order.
        drive(5'b01000, 5'b00000, 1'b1, 100);
        edge_wait();
        chk("bp first flit", out_flit, fl(3, 100));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            drive(5'b01000, 5'b00000, 1'b0, 101);
            #1 chk("bp in_ready", FW'(in_ready), 0);
            edge_wait();
            chk("bp hold flit", out_flit, fl(3, 100));
            chk("bp hold valid", FW'(out_valid), 1);
        end
        @(negedge clk);
        drive(5'b01000, 5'b00000, 1'b1, 101);
        #1 chk("bp release in_ready", FW'(in_ready), FW'(5'b01000));
        edge_wait();
        chk("bp second flit", out_flit, fl(3, 101));
        @(negedge clk);
        drive(5'b01000, 5'b01000, 1'b1, 102);
        edge_wait();
        chk("bp third flit", out_flit, fl(3, 102));
        chk("bp last", FW'(out_last), 1);
        chk("bp owner", FW'(out_owner), 3);
        @(negedge clk);
        drive('0, '0, 1'b1, 103);
        edge_wait();
        chk("bp drain valid", FW'(out_valid), 0);

        // Reset mid-packet drops the lock and resets the pointer.
        @(negedge clk);
        drive(5'b10000, 5'b00000, 1'b1, 110);
        edge_wait();
        chk("mid owner", FW'(out_owner), 4);
        @(negedge clk);
        rst = 1'b0;
        drive(5'b00101, 5'b00000, 1'b1, 111);
        #1 chk("mid reset in_ready", FW'(in_ready), 0);
        edge_wait();
        chk("mid reset valid", FW'(out_valid), 0);
        @(negedge clk);
        rst = 1'b1;
        drive(5'b00101, 5'b00101, 1'b1, 112);
        #1 chk("post reset in_ready", FW'(in_ready), FW'(5'b00001));
        edge_wait();
        chk("post reset owner", FW'(out_owner), 0);
        chk("post reset flit", out_flit, fl(0, 112));

`ifdef NOC_ARB_WATCHDOG_EN
        @(negedge clk);
        drive(5'b00010, 5'b00000, 1'b1, 120);
        edge_wait();
        chk("wd owner", FW'(out_owner), 1);
        for (int c = 1; c <= SL; c++) begin
            @(negedge clk);
            drive('0, '0, 1'b1, 121);
            edge_wait();
            chk($sformatf("wd stall c%0d", c), FW'(stall_err), FW'(c == SL));
        end
        @(negedge clk);
        drive(5'b00010, 5'b00010, 1'b1, 122);
        edge_wait();
        chk("wd finish owner", FW'(out_owner), 1);
        chk("wd sticky", FW'(stall_err), 1);
        @(negedge clk);
        rst = 1'b0;
        drive('0, '0, 1'b1, 123);
        edge_wait();
        chk("wd cleared", FW'(stall_err), 0);
        @(negedge clk);
        rst = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
